wb_bus_arbiter: RTL

- Shares one pipelined Wishbone memory port between two core masters.
- Master 0 is instruction fetch; master 1 is the memory-access (load/store) stage.
- Arbitrates per bus cycle, forwards the granted master combinationally to the slave, and tracks outstanding requests.
- Prevents starvation with round-robin arbitration and preemption at idle-bus points.

---
 rtl/wb_bus_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
// Two-master to one-slave pipelined Wishbone arbiter. Master 0 is the
// instruction-fetch port, master 1 is the load/store port. Ownership is
// decided in IDLE (one registered decision per bus cycle), the owner is muxed
// combinationally onto the slave, and a per-grant counter tracks requests the
// slave has accepted but not yet acknowledged. Round-robin on ties plus
// preemption at idle-bus points keeps either master from starving the other.

module wb_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rstn,

  // Master 0: instruction fetch
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  output logic                m0_stall,
  output logic [DATA_W-1:0]   m0_rdata,

  // Master 1: load/store
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic                m1_stall,
  output logic [DATA_W-1:0]   m1_rdata,

  // Shared slave port
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic                s_stall,
  input  logic [DATA_W-1:0]   s_rdata,

  // Current owner, one-hot {m1,m0}; 00 while idle
  output logic [1:0]          grant
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;   // 0 = m0 owned last, 1 = m1
  logic [CNT_W-1:0] outst_q, outst_d;

  logic             owned;       // some master holds the bus this cycle
  logic             own_cyc;
  logic             own_stb;
  logic             oth_cyc;
  logic             outst_full;
  logic             stb_gated;   // owner strobe after the outstanding limit
  logic             accept;      // slave takes a request this cycle
  logic             ack_cnt;     // ack that retires a tracked request
  logic [CNT_W-1:0] outst_nxt;   // counter after this cycle's traffic

  // Owner/other views of the masters; in IDLE these are don't-care.
  assign owned      = (state_q != IDLE);
  assign own_cyc    = (state_q == GNT1) ? m1_cyc : m0_cyc;
  assign own_stb    = (state_q == GNT1) ? m1_stb : m0_stb;
  assign oth_cyc    = (state_q == GNT1) ? m0_cyc : m1_cyc;
  assign outst_full = (outst_q == MAX_CNT);
  assign stb_gated  = owned && own_stb && !outst_full;
  assign accept     = stb_gated && !s_stall;
  // An ack with nothing outstanding is a slave protocol error; it must not
  // wrap the counter below zero.
  assign ack_cnt    = owned && s_ack && (outst_q != '0);

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  assign grant = {state_q == GNT1, state_q == GNT0};

  // Counter value at the end of this cycle, before any release clears it.
  always_comb begin
    outst_nxt = outst_q;
    if (accept && !ack_cnt) begin
      outst_nxt = outst_q + CNT_W'(1);
    end else if (!accept && ack_cnt) begin
      outst_nxt = outst_q - CNT_W'(1);
    end
  end

  // State, round-robin history and outstanding counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      outst_q      <= outst_d;
    end
  end

  // Next-state: grant decision in IDLE, cancel/preempt release while owned.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    outst_d      = outst_q;

    case (state_q)
      IDLE: begin
        outst_d = '0;
        // On a tie m0 wins only if m1 was the last owner.
        if (m0_cyc && (!m1_cyc || last_grant_q)) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (m1_cyc) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end

      GNT0, GNT1: begin
        outst_d = outst_nxt;
        if (!own_cyc) begin
          // Cancel: the owner abandoned the cycle; in-flight acks are orphaned.
          state_d = IDLE;
          outst_d = '0;
        end else if (!own_stb && oth_cyc && (outst_nxt == '0)) begin
          // Preempt: owner is idling with nothing in flight and the other
          // master is waiting.
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        outst_d = '0;
      end
    endcase
  end

  // Outputs: combinational mux of the owner onto the slave; non-owners stall.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_stall = 1'b1;
    m1_stall = 1'b1;

    case (state_q)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = stb_gated;
        s_we     = m0_we;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_sel    = m0_sel;
        m0_stall = s_stall || outst_full;
        m0_ack   = s_ack;
      end

      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = stb_gated;
        s_we     = m1_we;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_sel    = m1_sel;
        m1_stall = s_stall || outst_full;
        m1_ack   = s_ack;
      end

      default: ;
    endcase
  end

endmodule
